// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: circular byte FIFO feeding a UART transmitter, one byte in flight at a time,
// with optional CTS gating of each new dispatch.
module uart_tx_buffer #(
  parameter int data_bits_p = 8,
  parameter int els_p       = 16,
  parameter bit cts_en_p    = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          data_v_i,
  input  logic [data_bits_p-1:0]        data_i,
  output logic                          data_ready_and_o,
  output logic                          tx_v_o,
  output logic [data_bits_p-1:0]        tx_o,
  input  logic                          tx_ready_and_i,
  input  logic                          tx_done_i,
  input  logic                          cts_n_i,
  output logic [$clog2(els_p+1)-1:0]    count_o,
  output logic                          idle_o
);
  localparam int aw = $clog2(els_p);
  localparam int cw = $clog2(els_p+1);

  logic [data_bits_p-1:0] mem_q [els_p];
  logic [aw-1:0]          wr_ptr_q, rd_ptr_q;
  logic [cw-1:0]          count_q, count_d;
  logic                   in_flight_q, in_flight_d;
  logic                   cts_meta_q, cts_sync_q;
  logic                   enq, deq, cts_ok;

  assign cts_ok           = !cts_en_p || !cts_sync_q;
  assign data_ready_and_o = count_q != cw'(els_p);
  assign enq              = data_v_i && data_ready_and_o;
  assign tx_v_o           = (count_q != '0) && !in_flight_q && cts_ok;
  assign deq              = tx_v_o && tx_ready_and_i;
  // Storage is not cleared on reset, so the head is masked while empty.
  assign tx_o             = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o          = count_q;
  assign idle_o           = (count_q == '0) && !in_flight_q;

  always_comb begin
    count_d     = count_q + cw'(enq) - cw'(deq);
    in_flight_d = deq ? 1'b1 : (tx_done_i ? 1'b0 : in_flight_q);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_flight_q <= 1'b0;
      cts_meta_q  <= 1'b1;
      cts_sync_q  <= 1'b1;
    end else begin
      wr_ptr_q    <= enq ? wr_ptr_q + aw'(1) : wr_ptr_q;
      rd_ptr_q    <= deq ? rd_ptr_q + aw'(1) : rd_ptr_q;
      count_q     <= count_d;
      in_flight_q <= in_flight_d;
      cts_meta_q  <= cts_n_i;
      cts_sync_q  <= cts_meta_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= data_i;
  end
endmodule
